// File: rtl/bayer_bin2gray_pkg.sv
// Local types and helpers for the Bayer 2x2 binning stage.
package bayer_bin2gray_pkg;

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } row_e;

    // Green sites sit where row and column parity agree when g_even is set.
    function automatic logic is_green(input logic odd_row, input logic odd_col,
                                      input logic g_even);
        return (odd_row ~^ odd_col) == g_even;
    endfunction

endpackage : bayer_bin2gray_pkg

// File: rtl/img_pkg.sv
// Shared pixel types for the camera pipeline (bayer_bin2gray, image_proc).
package img_pkg;

    localparam int unsigned PIX_W = 12;

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [PIX_W:0]   pairsum_t;
    typedef logic [PIX_W+1:0] quadsum_t;

endpackage : img_pkg

// File: rtl/bayer_bin2gray_if.sv
// Raw Bayer input and binned grayscale output stream of bayer_bin2gray.
interface bayer_bin2gray_if;
    import img_pkg::*;

    pix_t iPIX12;
    logic iDVAL;
    logic iFVAL;
    pix_t oPIX12;
    logic oDVAL;

    modport master (output iPIX12, iDVAL, iFVAL, input oPIX12, oDVAL);
    modport slave  (input iPIX12, iDVAL, iFVAL, output oPIX12, oDVAL);

endinterface : bayer_bin2gray_if

// File: rtl/bayer_linebuf.sv
// Behavioural single-port RAM; read data registered on read enable and held.
module bayer_linebuf #(
    parameter int unsigned DEPTH  = 640,
    parameter int unsigned WIDTH  = 13,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule : bayer_linebuf

// File: rtl/bayer_bin2gray.sv
// Bins each 2x2 Bayer quad into one 12-bit gray pixel (W_IN/2 per row pair).
// BAYER_GREEN_ONLY_EN: average only the two green sites (layout from BAYER_G_EVEN).
module bayer_bin2gray
    import img_pkg::*;
    import bayer_bin2gray_pkg::*;
#(
    parameter int unsigned W_IN         = 1280,
    parameter bit          BAYER_G_EVEN = 1'b1
) (
    input  logic             iCLK,
    input  logic             iRST,
    bayer_bin2gray_if.slave  bus
);

    localparam int unsigned HALF_W = W_IN / 2;
    localparam int unsigned X_W    = (W_IN > 1) ? $clog2(W_IN) : 1;
    localparam int unsigned A_W    = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int unsigned LB_W   = PIX_W + 1;

    logic [X_W-1:0] x_q, x_d;
    row_e           row_q, row_d;
    pix_t           pair_q, pair_d;
    pix_t           opix_q, opix_d;
    logic           dval_q, dval_d;

    logic           lb_we, lb_re;
    logic [A_W-1:0] lb_addr;
    pairsum_t       lb_wdata, lb_rdata;
    pix_t           result;

    // Pair value stored on even rows and the gray result formed on odd rows.
`ifdef BAYER_GREEN_ONLY_EN
    pix_t     g_top, g_bot;
    pairsum_t gsum;
    always_comb begin
        g_top    = is_green(1'b0, 1'b0, BAYER_G_EVEN) ? pair_q : bus.iPIX12;
        g_bot    = is_green(1'b1, 1'b0, BAYER_G_EVEN) ? pair_q : bus.iPIX12;
        lb_wdata = pairsum_t'(g_top);
        gsum     = lb_rdata + pairsum_t'(g_bot);
        result   = pix_t'(gsum >> 1);
    end
`else
    quadsum_t qsum;
    logic     unused_g_even;
    assign unused_g_even = BAYER_G_EVEN;
    always_comb begin
        lb_wdata = pairsum_t'(pair_q) + pairsum_t'(bus.iPIX12);
        qsum     = quadsum_t'(lb_rdata) + quadsum_t'(pair_q) + quadsum_t'(bus.iPIX12);
        result   = pix_t'(qsum >> 2);
    end
`endif

    always_comb begin
        x_d     = x_q;
        row_d   = row_q;
        pair_d  = pair_q;
        opix_d  = opix_q;
        dval_d  = 1'b0;
        lb_we   = 1'b0;
        lb_re   = 1'b0;
        lb_addr = A_W'(x_q >> 1);

        if (!bus.iFVAL) begin
            x_d   = '0;
            row_d = ROW_EVEN;
        end else if (bus.iDVAL) begin
            if (x_q == X_W'(W_IN - 1)) begin
                x_d   = '0;
                row_d = (row_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
            end else begin
                x_d = x_q + X_W'(1);
            end

            if (!x_q[0]) begin
                pair_d = bus.iPIX12;
                lb_re  = (row_q == ROW_ODD);
            end else if (row_q == ROW_EVEN) begin
                lb_we = 1'b1;
            end else begin
                dval_d = 1'b1;
                opix_d = result;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            x_q    <= '0;
            row_q  <= ROW_EVEN;
            pair_q <= '0;
            opix_q <= '0;
            dval_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            row_q  <= row_d;
            pair_q <= pair_d;
            opix_q <= opix_d;
            dval_q <= dval_d;
        end
    end

    bayer_linebuf #(
        .DEPTH  (HALF_W),
        .WIDTH  (LB_W),
        .ADDR_W (A_W)
    ) u_linebuf (
        .clk_i   (iCLK),
        .we_i    (lb_we),
        .re_i    (lb_re),
        .addr_i  (lb_addr),
        .wdata_i (lb_wdata),
        .rdata_o (lb_rdata)
    );

    assign bus.oPIX12 = opix_q;
    assign bus.oDVAL  = dval_q;

endmodule : bayer_bin2gray

// File: tb/tb_bayer_bin2gray.sv
// Directed-vector bench for bayer_bin2gray with an 8-pixel line.
module tb_bayer_bin2gray;
    import img_pkg::*;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   pulse_cnt = 0;

    pix_t top [W];
    pix_t bot [W];
    pix_t expq [W/2];

    bayer_bin2gray_if bus ();

    bayer_bin2gray #(.W_IN(W), .BAYER_G_EVEN(1'b1)) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic fval, input logic dval, input pix_t p);
        rst        = r;
        bus.iFVAL  = fval;
        bus.iDVAL  = dval;
        bus.iPIX12 = p;
        @(posedge clk);
        #1;
        if (bus.oDVAL === 1'b1) pulse_cnt++;
    endtask

    // One valid pixel, then nbub bubble cycles; output must only follow closing pixels.
    task automatic send(input pix_t p, input logic exp_dv, input pix_t exp_p, input int nbub);
        step(1'b0, 1'b1, 1'b1, p);
        check_eq("odval", 32'(bus.oDVAL), 32'(exp_dv));
        if (exp_dv) check_eq("opix", 32'(bus.oPIX12), 32'(exp_p));
        for (int b = 0; b < nbub; b++) begin
            step(1'b0, 1'b1, 1'b0, 12'hABC);
            check_eq("bubble_odval", 32'(bus.oDVAL), 32'd0);
            if (exp_dv) check_eq("opix_hold", 32'(bus.oPIX12), 32'(exp_p));
        end
    endtask

    task automatic row_pair(input int nbub);
        for (int c = 0; c < W; c++) send(top[c], 1'b0, 12'd0, nbub);
        for (int c = 0; c < W; c++) send(bot[c], (c % 2) == 1, expq[c/2], nbub);
    endtask

    task automatic fill(input pix_t t, input pix_t b, input pix_t e);
        for (int c = 0; c < W; c++) begin
            top[c] = t;
            bot[c] = b;
        end
        for (int q = 0; q < W/2; q++) expq[q] = e;
    endtask

    initial begin
        bus.iPIX12 = '0;
        bus.iDVAL  = 1'b0;
        bus.iFVAL  = 1'b0;

        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 12'd77);
        check_eq("reset_odval", 32'(bus.oDVAL), 32'd0);
        check_eq("reset_opix", 32'(bus.oPIX12), 32'd0);

        // Constant 100 over two row pairs
        pulse_cnt = 0;
        fill(12'd100, 12'd100, 12'd100);
        row_pair(0);
        row_pair(0);
        check_eq("const_pulses", 32'(pulse_cnt), 32'd8);

        // Corner quads: R-only, greens-only, 1/2/3/4, all full-scale
        top = '{12'd0, 12'd4095, 12'd4095, 12'd0, 12'd1, 12'd2, 12'd4095, 12'd4095};
        bot = '{12'd0, 12'd0, 12'd0, 12'd4095, 12'd3, 12'd4, 12'd4095, 12'd4095};
`ifdef BAYER_GREEN_ONLY_EN
        expq = '{12'd0, 12'd4095, 12'd2, 12'd4095};
`else
        expq = '{12'd1023, 12'd2047, 12'd2, 12'd4095};
`endif
        row_pair(0);

        // Same quads with three bubbles after every pixel
        pulse_cnt = 0;
        row_pair(3);
        check_eq("bubble_pulses", 32'(pulse_cnt), 32'd4);

        // Frame drop after three pixels of the odd row
        fill(12'd200, 12'd300, 12'd250);
        for (int c = 0; c < W; c++) send(top[c], 1'b0, 12'd0, 0);
        send(12'd300, 1'b0, 12'd0, 0);
        send(12'd300, 1'b1, 12'd250, 0);
        send(12'd300, 1'b0, 12'd0, 0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b1, 12'd999);
            check_eq("fdrop_odval", 32'(bus.oDVAL), 32'd0);
        end
        pulse_cnt = 0;
        fill(12'd40, 12'd80, 12'd60);
        row_pair(0);
        check_eq("restart_pulses", 32'(pulse_cnt), 32'd4);

        // Reset in the middle of an odd row
        for (int c = 0; c < W; c++) send(top[c], 1'b0, 12'd0, 0);
        for (int c = 0; c < 5; c++) send(bot[c], (c % 2) == 1, 12'd60, 0);
        step(1'b1, 1'b1, 1'b1, 12'd80);
        check_eq("midrst_odval", 32'(bus.oDVAL), 32'd0);
        check_eq("midrst_opix", 32'(bus.oPIX12), 32'd0);
        pulse_cnt = 0;
        fill(12'd8, 12'd16, 12'd12);
        row_pair(0);
        check_eq("postrst_pulses", 32'(pulse_cnt), 32'd4);

        // Reset together with frame-valid low, then idle
        step(1'b1, 1'b0, 1'b1, 12'd5);
        check_eq("rst_fval_odval", 32'(bus.oDVAL), 32'd0);
        check_eq("rst_fval_opix", 32'(bus.oPIX12), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bayer_bin2gray
